// File: rtl/system.sv
// rtl/system.sv - memory-to-memory pair add/subtract transfer engine
//
// Purpose: fills an 8x8 memory A from DataInA, then reads consecutive
// pairs from A and stores (DOut1 > DOut2 ? DOut1-DOut2 : DOut1+DOut2)
// into a 4x8 memory B, sequenced by a 5-bit Moore controller.
//
// Ports:
//   clock    in   1  rising-edge clock
//   Reset    in   1  asynchronous active-low reset
//   DataInA  in   8  write data for memory A
//   AddrA    out  3  memory A address counter
//   AddrB    out  2  memory B address counter
//   DOut1    out  8  first operand (even word of pair)
//   DOut2    out  8  second operand (odd word of pair)
//   ADDOut   out  8  DOut1 + DOut2
//   SUBOut   out  8  DOut1 - DOut2
//   WEA/IncA out  1  memory A write enable / address increment
//   WEB/IncB out  1  memory B write enable / address increment
//   ps       out  5  present state
//   ns       out  5  next state
//
// Build option: define SAT_ARITH_EN for saturating add / clamping subtract.

module system (
    input  logic       clock,
    input  logic       Reset,
    input  logic [7:0] DataInA,
    output logic [2:0] AddrA,
    output logic [1:0] AddrB,
    output logic [7:0] DOut1,
    output logic [7:0] DOut2,
    output logic [7:0] ADDOut,
    output logic [7:0] SUBOut,
    output logic       WEA,
    output logic       IncA,
    output logic       WEB,
    output logic       IncB,
    output logic [4:0] ps,
    output logic [4:0] ns
);

    typedef enum logic [4:0] {
        INIT = 5'd0,
        WRA  = 5'd1,
        RD1  = 5'd2,
        RD2  = 5'd3,
        WRB  = 5'd4,
        DONE = 5'd5
    } state_t;

    state_t     ps_q, ns_d;
    logic [2:0] addr_a_q, addr_a_d;
    logic [1:0] addr_b_q, addr_b_d;
    logic [7:0] dout1_q, dout1_d;
    logic [7:0] dout2_q, dout2_d;
    logic [7:0] wb_data;

    // Memories are deliberately not reset; contents survive a Reset pulse.
    logic [7:0] mem_a [8];
    logic [7:0] mem_b [4];

    // Controller: strobes and next state depend only on the present state.
    always_comb begin
        ns_d = INIT;
        WEA  = 1'b0;
        IncA = 1'b0;
        WEB  = 1'b0;
        IncB = 1'b0;
        case (ps_q)
            INIT: ns_d = WRA;
            WRA: begin
                WEA  = 1'b1;
                IncA = 1'b1;
                ns_d = (addr_a_q == 3'd7) ? RD1 : WRA;
            end
            RD1: begin
                IncA = 1'b1;
                ns_d = RD2;
            end
            RD2: begin
                IncA = 1'b1;
                ns_d = WRB;
            end
            WRB: begin
                WEB  = 1'b1;
                IncB = 1'b1;
                ns_d = (addr_b_q == 2'd3) ? DONE : RD1;
            end
            DONE:    ns_d = DONE;
            default: ns_d = INIT;
        endcase
    end

    // Datapath next-state: counters wrap naturally at their width.
    always_comb begin
        addr_a_d = IncA ? addr_a_q + 3'd1 : addr_a_q;
        addr_b_d = IncB ? addr_b_q + 2'd1 : addr_b_q;
        dout1_d  = (ps_q == RD1) ? mem_a[addr_a_q] : dout1_q;
        dout2_d  = (ps_q == RD2) ? mem_a[addr_a_q] : dout2_q;
    end

`ifdef SAT_ARITH_EN
    logic [8:0] sum9;
    always_comb begin
        sum9   = {1'b0, dout1_q} + {1'b0, dout2_q};
        ADDOut = sum9[8] ? 8'hFF : sum9[7:0];
        SUBOut = (dout2_q > dout1_q) ? 8'h00 : dout1_q - dout2_q;
    end
`else
    always_comb begin
        ADDOut = dout1_q + dout2_q;
        SUBOut = dout1_q - dout2_q;
    end
`endif

    // Equal operands fall through to the sum.
    assign wb_data = (dout1_q > dout2_q) ? SUBOut : ADDOut;

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            ps_q     <= INIT;
            addr_a_q <= 3'd0;
            addr_b_q <= 2'd0;
            dout1_q  <= 8'd0;
            dout2_q  <= 8'd0;
        end else begin
            ps_q     <= ns_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            dout1_q  <= dout1_d;
            dout2_q  <= dout2_d;
        end
    end

    always_ff @(posedge clock) begin
        if (WEA) mem_a[addr_a_q] <= DataInA;
        if (WEB) mem_b[addr_b_q] <= wb_data;
    end

    assign AddrA = addr_a_q;
    assign AddrB = addr_b_q;
    assign DOut1 = dout1_q;
    assign DOut2 = dout2_q;
    assign ps    = ps_q;
    assign ns    = ns_d;

endmodule

// File: tb/tb_system.sv
// tb/tb_system.sv - self-checking bench for system (table vectors + random model runs)

module tb_system;

    logic       clock = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] DataInA = 8'd0;
    logic [2:0] AddrA;
    logic [1:0] AddrB;
    logic [7:0] DOut1, DOut2, ADDOut, SUBOut;
    logic       WEA, IncA, WEB, IncB;
    logic [4:0] ps, ns;

    system dut (
        .clock   (clock),
        .Reset   (Reset),
        .DataInA (DataInA),
        .AddrA   (AddrA),
        .AddrB   (AddrB),
        .DOut1   (DOut1),
        .DOut2   (DOut2),
        .ADDOut  (ADDOut),
        .SUBOut  (SUBOut),
        .WEA     (WEA),
        .IncA    (IncA),
        .WEB     (WEB),
        .IncB    (IncB),
        .ps      (ps),
        .ns      (ns)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] d;     // byte i = i-th word written into A
        logic [31:0] b;     // byte i = expected MemB[i]
        logic [7:0]  sub0;  // expected SUBOut during the first WRB
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] cur [8];
    logic [7:0] first_sub;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference timeline: 1 INIT, 8 WRA, 4 x (RD1,RD2,WRB), then DONE forever.
    function automatic int exp_state(input int c);
        if (c == 0) return 0;
        if (c <= 8) return 1;
        if (c <= 20) return 2 + (c - 9) % 3;
        return 5;
    endfunction

    function automatic int model_add(input int a, input int b);
`ifdef SAT_ARITH_EN
        return (a + b > 255) ? 255 : a + b;
`else
        return (a + b) % 256;
`endif
    endfunction

    function automatic int model_sub(input int a, input int b);
`ifdef SAT_ARITH_EN
        return (b > a) ? 0 : a - b;
`else
        return (a - b + 256) % 256;
`endif
    endfunction

    function automatic int model_store(input int a, input int b);
        return (a > b) ? model_sub(a, b) : model_add(a, b);
    endfunction

    task automatic check_strobes(input int s, input string tag);
        check({tag, " WEA"},  {31'd0, WEA},  (s == 1) ? 1 : 0);
        check({tag, " IncA"}, {31'd0, IncA}, (s >= 1 && s <= 3) ? 1 : 0);
        check({tag, " WEB"},  {31'd0, WEB},  (s == 4) ? 1 : 0);
        check({tag, " IncB"}, {31'd0, IncB}, (s == 4) ? 1 : 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " ps"},    {27'd0, ps},    0);
        check({tag, " ns"},    {27'd0, ns},    1);
        check({tag, " AddrA"}, {29'd0, AddrA}, 0);
        check({tag, " AddrB"}, {30'd0, AddrB}, 0);
        check({tag, " DOut1"}, {24'd0, DOut1}, 0);
        check({tag, " DOut2"}, {24'd0, DOut2}, 0);
        check_strobes(0, tag);
    endtask

    // Assert reset away from the edge, check it, release on the next negedge.
    task automatic apply_reset();
        @(negedge clock);
        Reset = 1'b0;
        #1;
        check_reset_state("reset");
        @(negedge clock);
        Reset = 1'b1;
    endtask

    // Runs from just after reset release. abort_at >= 0 asserts Reset in that cycle.
    task automatic run_transfer(input int abort_at);
        int s, p;
        for (int c = 0; c <= 21; c++) begin
            s = exp_state(c);
            if (c == abort_at) begin
                Reset = 1'b0;
                #1;
                check_reset_state("abort");
                return;
            end
            check("ps", {27'd0, ps}, s);
            check("ns", {27'd0, ns}, exp_state(c + 1));
            check_strobes(s, "run");
            if (s == 1) DataInA = cur[c - 1];
            else        DataInA = 8'($urandom);
            if (s == 4) begin
                p = (c - 9) / 3;
                check("DOut1",  {24'd0, DOut1},  cur[2*p]);
                check("DOut2",  {24'd0, DOut2},  cur[2*p+1]);
                check("ADDOut", {24'd0, ADDOut}, model_add(cur[2*p], cur[2*p+1]));
                check("SUBOut", {24'd0, SUBOut}, model_sub(cur[2*p], cur[2*p+1]));
                check("AddrB",  {30'd0, AddrB},  p);
                if (p == 0) first_sub = SUBOut;
            end
            if (c == 21) break;
            @(negedge clock);
        end
        check("end AddrA", {29'd0, AddrA}, 0);
        check("end AddrB", {30'd0, AddrB}, 0);
        for (int i = 0; i < 8; i++) check("MemA", {24'd0, dut.mem_a[i]}, cur[i]);
        for (int i = 0; i < 4; i++)
            check("MemB model", {24'd0, dut.mem_b[i]}, model_store(cur[2*i], cur[2*i+1]));
    endtask

    task automatic hold_done();
        logic [7:0] b_snap [4];
        for (int i = 0; i < 4; i++) b_snap[i] = 8'(model_store(cur[2*i], cur[2*i+1]));
        for (int k = 0; k < 10; k++) begin
            DataInA = 8'($urandom);
            @(negedge clock);
            check("hold ps", {27'd0, ps}, 5);
            check_strobes(5, "hold");
        end
        for (int i = 0; i < 8; i++) check("hold MemA", {24'd0, dut.mem_a[i]}, cur[i]);
        for (int i = 0; i < 4; i++) check("hold MemB", {24'd0, dut.mem_b[i]}, b_snap[i]);
    endtask

    vec_t vecs [3];

    initial begin
        vecs[0].d    = {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        vecs[0].b    = {8'd13, 8'd9, 8'd5, 8'd1};
        vecs[1].d    = {8'd255, 8'd0, 8'd4, 8'd20, 8'd3, 8'd3, 8'd3, 8'd9};
        vecs[1].b    = {8'd255, 8'd16, 8'd6, 8'd6};
        vecs[1].sub0 = 8'd6;
        vecs[2].d    = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd200, 8'd100};
`ifdef SAT_ARITH_EN
        vecs[0].sub0 = 8'd0;
        vecs[2].b    = {8'd0, 8'd0, 8'd0, 8'd255};
        vecs[2].sub0 = 8'd0;
`else
        vecs[0].sub0 = 8'd255;
        vecs[2].b    = {8'd0, 8'd0, 8'd0, 8'd44};
        vecs[2].sub0 = 8'd156;
`endif

        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 8; i++) cur[i] = vecs[v].d[8*i +: 8];
            apply_reset();
            run_transfer(-1);
            for (int i = 0; i < 4; i++)
                check("MemB table", {24'd0, dut.mem_b[i]}, {24'd0, vecs[v].b[8*i +: 8]});
            check("first SUBOut", {24'd0, first_sub}, {24'd0, vecs[v].sub0});
            if (v == 0) hold_done();
        end

        // Abort in the second RD2, then a clean restart.
        for (int i = 0; i < 8; i++) cur[i] = 8'($urandom_range(1, 255));
        apply_reset();
        run_transfer(13);
        @(negedge clock);
        Reset = 1'b1;
        run_transfer(-1);

        // Random fills against the reference model.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) cur[i] = 8'($urandom);
            if (r == 0) begin cur[0] = 8'd255; cur[1] = 8'd255; cur[2] = 8'd0; cur[3] = 8'd255; end
            apply_reset();
            run_transfer(-1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/system.md
Name: system

Overview:
- Memory-to-memory transfer engine.
- Fills an 8x8 memory A from the DataInA stream, then reads consecutive pairs from A.
- For each pair it computes a sum or difference and stores the result in a 4x8 memory B.
- A 5-bit controller FSM sequences the block. State, address counters, read data, arithmetic results and control strobes are exported for observation.

Parameters:
- none; memory sizes fixed (A: 8 words x 8 bits, B: 4 words x 8 bits).

Ports:
- clock  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-low reset.
- DataInA  input  8  write data for memory A.
- AddrA  output  3  memory A address counter.
- AddrB  output  2  memory B address counter.
- DOut1  output  8  first operand register (even word of pair).
- DOut2  output  8  second operand register (odd word of pair).
- ADDOut  output  8  DOut1 + DOut2 (combinational).
- SUBOut  output  8  DOut1 - DOut2 (combinational).
- WEA  output  1  memory A write enable.
- IncA  output  1  AddrA increment strobe.
- WEB  output  1  memory B write enable.
- IncB  output  1  AddrB increment strobe.
- ps  output  5  present state.
- ns  output  5  next state (combinational).

Behaviour:
- Reset (Reset=0, asynchronous):
  - ps=INIT; AddrA=0, AddrB=0, DOut1=0, DOut2=0.
  - Memory contents are not cleared.
  - Reset mid-operation aborts and restarts from INIT.
- State codes:
  - INIT=0, WRA=1, RD1=2, RD2=3, WRB=4, DONE=5.
  - Unused codes go to INIT.
- INIT: all strobes 0; ns=WRA.
- WRA: WEA=1, IncA=1.
  - At each rising edge: MemA[AddrA] <= DataInA, then AddrA increments.
  - When AddrA==7, ns=RD1 and AddrA wraps to 0; otherwise ns=WRA.
  - Exactly 8 writes.
- RD1: IncA=1; DOut1 <= MemA[AddrA] (combinational read, registered at edge); ns=RD2.
- RD2: IncA=1; DOut2 <= MemA[AddrA]; ns=WRB.
- WRB: WEB=1, IncB=1.
  - MemB[AddrB] <= (DOut1 > DOut2) ? SUBOut : ADDOut.
  - AddrB increments.
  - If AddrB==3, ns=DONE (AddrB wraps to 0); else ns=RD1.
- DONE: all strobes 0; hold until reset.
- Strobes and ns are pure functions of ps (Moore).
- Counters change only on edges where the corresponding Inc is 1.
- Timeline after reset release:
  - 1 INIT cycle, 8 WRA cycles, 4 x (RD1, RD2, WRB) = 12 cycles, then DONE.
  - 21 cycles total to DONE.
- Arithmetic: 8-bit, modulo 256 unless the optional feature is enabled.
- Equal operands: DOut1 == DOut2 selects ADDOut.

Optional Feature:
- Macro: SAT_ARITH_EN.
- Defined:
  - ADDOut saturates at 255 when the 9-bit sum exceeds 255.
  - SUBOut clamps to 0 when DOut2 > DOut1.
  - MemB receives the saturated/clamped value.
- Undefined: both outputs wrap modulo 256.

Test Plan:
- Reset held low, then released with DataInA=0..7 one per WRA cycle:
  - ps steps 0,1(x8),2,3,4 repeated, then 5.
  - MemA = 0..7.
  - MemB = 1,5,9,13 (all ADD).
  - AddrA ends 0, AddrB ends 0.
- DataInA = 9,3,3,3,20,4,0,255:
  - MemB = 6 (SUB, 9>3), 6 (ADD, equal operands), 16 (SUB), 255 (ADD).
- Pair (100,200), SAT_ARITH_EN undefined:
  - ADDOut = 44, stored in MemB.
  - SUBOut shows 156 during WRB.
- Same pair, SAT_ARITH_EN defined:
  - ADDOut = 255 stored.
  - SUBOut = 0.
- Reset asserted during the second RD2:
  - Immediately ps=0, AddrA=0, AddrB=0, DOut1=DOut2=0, all strobes 0.
  - After release the fill restarts from WRA.
- After DONE, keep clocking 10 cycles with DataInA changing:
  - ps stays 5; WEA, WEB, IncA, IncB stay 0.
  - Neither memory changes.
